data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning RAM size in 32-bit words (power of two, 16..65536).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port ce_i  input  1  access request from core (core's data_ce_o).
REQ-005 The block SHALL have port we_i  input  1  1 = store, 0 = load; sampled only when ce_i=1.
REQ-006 The block SHALL have port addr_i  input  32  byte address from core.
REQ-007 The block SHALL have port data_i  input  32  store data from core.
REQ-008 The block SHALL have port data_o  output  32  load data to core (core's data_i).
REQ-009 The block SHALL have port ready_o  output  1  1 = block accepts accesses.
REQ-010 The block SHALL have port err_o  output  1  sticky fault flag.
REQ-011 The block SHALL have port err_addr_o  output  32  address of the first faulting access.

Function
REQ-012 The block SHALL have an FSM with states CLEAR and READY; ready_o SHALL be 1 only in READY.
REQ-013 In CLEAR, the block SHALL write 0 to word index cnt each cycle, cnt counting 0..DEPTH-1, then enter READY on the cycle after writing DEPTH-1 (DEPTH cycles total in CLEAR).
REQ-014 An access SHALL be accepted when ready_o=1 and ce_i=1; word index = addr_i[log2(DEPTH)+1:2].
REQ-015 An access SHALL fault when addr_i[1:0]!=0 or addr_i>=DEPTH*4; a faulting access SHALL NOT modify RAM or data_o.
REQ-016 An accepted non-faulting store SHALL write data_i to RAM at the rising edge; data_o SHALL be unchanged.
REQ-017 An accepted non-faulting load SHALL update data_o to RAM[index] at the rising edge (1-cycle latency); data_o SHALL hold until the next such load.
REQ-018 A load in the cycle directly after a store to the same index SHALL return the newly stored value.
REQ-019 On the first fault since reset, err_o SHALL go 1 and err_addr_o SHALL capture addr_i; later faults SHALL NOT change err_addr_o; err_o SHALL stay 1 until reset.
REQ-020 A request with ce_i=1 while ready_o=0 SHALL be ignored: no RAM write, no data_o change, and no fault.
REQ-021 With ce_i=0, we_i/addr_i/data_i SHALL have no effect.
REQ-022 Address bits above the index SHALL only participate in the range check, not in wrap-around; no aliasing SHALL occur.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL set data_o=0, err_o=0, err_addr_o=0, and cnt=0.
REQ-024 While rst=1 at a rising edge, the FSM SHALL enter CLEAR (or READY if DATA_MEM_CLEAR_EN is undefined), so ready_o=0 on the following cycle when clearing.
REQ-025 Reset asserted mid-CLEAR or mid-operation SHALL restart the sequence from cnt=0; RAM contents SHALL NOT be reset directly.
REQ-026 A request presented in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-027 With macro DATA_MEM_CLEAR_EN defined, the block SHALL implement the CLEAR sweep of REQ-013.
REQ-028 With DATA_MEM_CLEAR_EN undefined, CLEAR and cnt SHALL be omitted, and reset SHALL go straight to READY (ready_o=1 one cycle after rst deasserts).
REQ-029 With DATA_MEM_CLEAR_EN undefined, RAM contents after reset SHALL be undefined, or preserved across reset.

Verification
REQ-030 The bench SHALL cover: DEPTH=1024, CLEAR_EN, rst 1 cycle then release -> ready_o=0 for exactly 1024 cycles then 1; a load of 0x0000_0FFC returns 0.
REQ-031 The bench SHALL cover: store 0xDEADBEEF to 0x10, load 0x10 next cycle -> data_o=0xDEADBEEF one cycle after load; data_o unchanged during the store cycle.
REQ-032 The bench SHALL cover: load 0x0000_0002 then 0x0000_1000 -> err_o=1, err_addr_o=0x0000_0002, data_o unchanged, RAM unchanged.
REQ-033 The bench SHALL cover: store to 0x20 issued while ready_o=0 -> after ready_o=1, load 0x20 returns 0 and err_o=0.
REQ-034 The bench SHALL cover: rst at cnt=500 -> ready_o stays 0 for another full 1024 cycles; err_o cleared.
REQ-035 The bench SHALL cover: DATA_MEM_CLEAR_EN undefined -> ready_o=1 on the first cycle after rst deasserts; store/load 0x4 = 0x12345678 round-trips.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data RAM serving a core's load/store port, with alignment/range fault capture.
// Optional macro DATA_MEM_CLEAR_EN adds a post-reset zeroing sweep before accesses are accepted.
module data_mem_resp #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 32;

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
`else
  typedef enum logic [0:0] {
    S_READY = 1'b1
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          fault;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          flt_en;

  // Upper address bits only feed the range check, so out-of-range never aliases.
  assign idx   = addr_i[AW+1:2];
  assign fault = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DATA_MEM_CLEAR_EN
      state <= S_CLEAR;
      cnt   <= '0;
`else
      state <= S_READY;
`endif
    end else begin
      state <= state_nxt;
`ifdef DATA_MEM_CLEAR_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
`ifdef DATA_MEM_CLEAR_EN
    cnt_nxt   = cnt;
    if (state == S_CLEAR) begin
      cnt_nxt = cnt + AW'(1);
      if (cnt == AW'(DEPTH - 1)) begin
        state_nxt = S_READY;
      end
    end
`endif
  end

  // Output / datapath control decode
  always_comb begin
    ready_o = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = data_i;
    rd_en   = 1'b0;
    flt_en  = 1'b0;

    ready_o = (state == S_READY);

    if (!rst) begin
`ifdef DATA_MEM_CLEAR_EN
      if (state == S_CLEAR) begin
        wr_en   = 1'b1;
        wr_idx  = cnt;
        wr_data = '0;
      end
`endif
      if ((state == S_READY) && ce_i) begin
        if (fault) begin
          flt_en = 1'b1;
        end else if (we_i) begin
          wr_en = 1'b1;
        end else begin
          rd_en = 1'b1;
        end
      end
    end
  end

  // RAM array: single write port, contents untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read data and sticky fault capture
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o     <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      if (rd_en) begin
        data_o <= mem[idx];
      end
      if (flt_en && !err_o) begin
        err_o      <= 1'b1;
        err_addr_o <= addr_i;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: reference model compared every cycle plus directed literal checks.
// Follows DATA_MEM_CLEAR_EN the same way the design does.
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 1024;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        ce   = 1'b0;
  logic        we   = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din  = '0;
  logic [31:0] data_o;
  logic        ready_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  int n_assert = 0;
  int n_fail   = 0;

  data_mem_resp #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce),
    .we_i       (we),
    .addr_i     (addr),
    .data_i     (din),
    .data_o     (data_o),
    .ready_o    (ready_o),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an array, readiness as a countdown of clear cycles
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_data;
  bit          m_data_known = 0;
  bit          m_ready      = 0;
  bit          m_err        = 0;
  logic [31:0] m_err_addr   = '0;
  bit          m_live       = 0;
`ifdef DATA_MEM_CLEAR_EN
  int          m_clear_left = 0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_live       = 1;
      m_data       = '0;
      m_data_known = 1;
      m_err        = 0;
      m_err_addr   = '0;
`ifdef DATA_MEM_CLEAR_EN
      m_clear_left = DEPTH;
      m_ready      = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = '0;
        m_known[i] = 1;
      end
`else
      m_ready = 1;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
`endif
    end else if (m_live) begin
      if (!m_ready) begin
`ifdef DATA_MEM_CLEAR_EN
        if (m_clear_left > 0) m_clear_left--;
        if (m_clear_left == 0) m_ready = 1;
`endif
      end else if (ce) begin
        if ((addr[1:0] != 2'b00) || (addr >= DEPTH * 4)) begin
          if (!m_err) begin
            m_err      = 1;
            m_err_addr = addr;
          end
        end else if (we) begin
          m_mem[addr / 4]   = din;
          m_known[addr / 4] = 1;
        end else begin
          m_data       = m_mem[addr / 4];
          m_data_known = m_known[addr / 4];
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("ready_o", {31'b0, ready_o}, {31'b0, m_ready});
      chk("err_o", {31'b0, err_o}, {31'b0, m_err});
      chk("err_addr_o", err_addr_o, m_err_addr);
      if (m_data_known) chk("data_o", data_o, m_data);
    end
  end

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce   = c;
    we   = w;
    addr = a;
    din  = d;
  endtask

`ifdef DATA_MEM_CLEAR_EN
  // Counts not-ready cycles after reset release; injects a store to 0x20 early in the sweep
  task automatic wait_clear(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 3000) begin
      n++;
      if (n == 10) begin
        ce = 1; we = 1; addr = 32'h20; din = 32'h5555_AAAA;
      end else if (n == 11) begin
        ce = 0; we = 0;
      end
      @(negedge clk);
    end
    ce = 0;
  endtask
`endif

  logic [31:0] exp_prev;
  int          n;

  initial begin
    // Reset with a request that must be ignored
    @(negedge clk);
    rst = 1; ce = 1; we = 1; addr = 32'h24; din = 32'h77;
    @(negedge clk);
    rst = 0; ce = 0; we = 0;

`ifdef DATA_MEM_CLEAR_EN
    chk("ready_after_rst", {31'b0, ready_o}, 32'd0);
    chk("data_after_rst", data_o, 32'h0);
    wait_clear(n);
    chk("clear_len", 32'(n), 32'd1024);
    drive(1, 0, 32'h0000_0FFC, 0);
    drive(0, 0, 0, 0);
    chk("load_ffc_cleared", data_o, 32'h0);
    drive(1, 0, 32'h20, 0);
    drive(1, 0, 32'h24, 0);
    chk("store_while_clear_ignored", data_o, 32'h0);
    chk("no_err_while_clear", {31'b0, err_o}, 32'd0);
    drive(0, 0, 0, 0);
    chk("store_in_rst_ignored", data_o, 32'h0);
    exp_prev = 32'h0;
`else
    chk("ready_first_cycle", {31'b0, ready_o}, 32'd1);
    drive(1, 1, 32'h4, 32'h1234_5678);
    drive(1, 0, 32'h4, 0);
    chk("data_hold_on_store4", data_o, 32'h0);
    drive(0, 0, 0, 0);
    chk("roundtrip_4", data_o, 32'h1234_5678);
    exp_prev = 32'h1234_5678;
`endif

    // Store then immediate load of the same word
    drive(1, 1, 32'h10, 32'hDEAD_BEEF);
    drive(1, 0, 32'h10, 0);
    chk("data_hold_on_store", data_o, exp_prev);
    drive(0, 0, 0, 0);
    chk("load_after_store", data_o, 32'hDEAD_BEEF);

    // Top word of the array
    drive(1, 1, 32'h0000_0FFC, 32'hCAFE_F00D);
    drive(1, 0, 32'h0000_0FFC, 0);
    drive(0, 0, 0, 0);
    chk("top_word", data_o, 32'hCAFE_F00D);

    // Misaligned then out-of-range: first fault address sticks
    drive(1, 0, 32'h0000_0002, 0);
    drive(1, 0, 32'h0000_1000, 0);
    chk("err_set", {31'b0, err_o}, 32'd1);
    chk("err_addr_first", err_addr_o, 32'h0000_0002);
    drive(1, 1, 32'h0000_1010, 32'h1);
    chk("err_addr_kept", err_addr_o, 32'h0000_0002);
    chk("fault_data_hold", data_o, 32'hCAFE_F00D);
    drive(1, 1, 32'h0000_0012, 32'h2);
    drive(0, 1, 32'h10, 32'hFFFF_FFFF);
    drive(1, 0, 32'h10, 0);
    drive(0, 0, 0, 0);
    chk("no_alias_no_write", data_o, 32'hDEAD_BEEF);
    chk("err_sticky", {31'b0, err_o}, 32'd1);

`ifdef DATA_MEM_CLEAR_EN
    // Reset, then reset again at cnt=500
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("err_cleared", {31'b0, err_o}, 32'd0);
    repeat (500) @(negedge clk);
    chk("still_clearing", {31'b0, ready_o}, 32'd0);
    rst = 1;
    @(negedge clk); rst = 0;
    wait_clear(n);
    chk("reclear_len", 32'(n), 32'd1024);
    chk("err_clear_after_reclear", {31'b0, err_o}, 32'd0);
    drive(1, 0, 32'h10, 0);
    drive(0, 0, 0, 0);
    chk("ram_zeroed", data_o, 32'h0);
`else
    // Mid-operation reset clears flags; store/load still works
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("err_cleared", {31'b0, err_o}, 32'd0);
    chk("err_addr_cleared", err_addr_o, 32'h0);
    chk("ready_after_rerst", {31'b0, ready_o}, 32'd1);
    drive(1, 1, 32'h4, 32'h1234_5678);
    drive(1, 0, 32'h4, 0);
    drive(0, 0, 0, 0);
    chk("roundtrip_4_again", data_o, 32'h1234_5678);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
